// File: rtl/lowx_mem_responder.sv
// rtl/lowx_mem_responder.sv - memory-side responder for the cache lowX request/response interface
//
// Purpose: block-organised backing RAM that serves line fills, writebacks and
// uncached word/subword accesses with a fixed response latency.
// Optional macro LOWX_MEM_STALL_EN: adds a pseudo-random 0..7 cycle stall per
// request from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   lowx_req_*            request channel (valid/ready, addr, rw, size, data, uncached)
//   lowx_res_*            response channel (valid/ready, data)
module lowx_mem_responder #(
    parameter int BLK_SIZE  = 128,
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lowx_req_valid_i,
    output logic                lowx_req_ready_o,
    input  logic [XLEN-1:0]     lowx_req_addr_i,
    input  logic                lowx_req_rw_i,
    input  logic [1:0]          lowx_req_rw_size_i,
    input  logic [BLK_SIZE-1:0] lowx_req_data_i,
    input  logic                lowx_req_uncached_i,
    output logic                lowx_res_valid_o,
    input  logic                lowx_res_ready_i,
    output logic [BLK_SIZE-1:0] lowx_res_data_o
);

    localparam int OFF  = $clog2(BLK_SIZE / 8);
    localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef LOWX_MEM_STALL_EN
    localparam int CNT_MAX = LATENCY + 6;
`else
    localparam int CNT_MAX = LATENCY - 1;
`endif
    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("lowx_mem_responder: LATENCY must be >= 1");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BLK_SIZE-1:0] res_data_q, res_data_d;
    logic [BLK_SIZE-1:0] mem_q [MEM_DEPTH];

    logic                accept;
    logic [IDXW-1:0]     idx;
    logic [OFF-1:0]      byte_off;
    logic [OFF-1:0]      lane;
    logic [31:0]         sub_mask;
    logic [OFF+2:0]      wr_sh;
    logic [OFF+2:0]      rd_sh;
    logic [BLK_SIZE-1:0] cur_line;
    logic [BLK_SIZE-1:0] wr_mask;
    logic [BLK_SIZE-1:0] wr_bits;
    logic [BLK_SIZE-1:0] new_line;
    logic [BLK_SIZE-1:0] rd_data;
    logic [31:0]         rd_word;
    logic [CW-1:0]       stall;

    // Ready is forced low while reset is held so nothing commits during reset.
    assign lowx_req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept           = lowx_req_valid_i && lowx_req_ready_o;
    assign lowx_res_valid_o = (state_q == S_RESP);
    assign lowx_res_data_o  = res_data_q;

    // Line index wraps modulo the array depth.
    assign idx      = IDXW'((lowx_req_addr_i >> OFF) % XLEN'(MEM_DEPTH));
    assign byte_off = lowx_req_addr_i[OFF-1:0];
    assign cur_line = mem_q[idx];

    // Subword lane alignment: half ignores addr[0], word ignores addr[1:0].
    always_comb begin
        lane     = byte_off;
        sub_mask = 32'h0000_00FF;
        case (lowx_req_rw_size_i)
            2'd0: begin
                lane     = byte_off;
                sub_mask = 32'h0000_00FF;
            end
            2'd1: begin
                lane     = byte_off & ~OFF'(1);
                sub_mask = 32'h0000_FFFF;
            end
            default: begin
                lane     = byte_off & ~OFF'(3);
                sub_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign wr_sh    = (OFF+3)'(lane) << 3;
    assign wr_mask  = BLK_SIZE'(sub_mask) << wr_sh;
    assign wr_bits  = BLK_SIZE'(lowx_req_data_i[31:0] & sub_mask) << wr_sh;
    assign new_line = lowx_req_uncached_i ? ((cur_line & ~wr_mask) | wr_bits)
                                          : lowx_req_data_i;

    // Uncached reads return the aligned word containing the address.
    assign rd_sh   = (OFF+3)'(byte_off >> 2) << 5;
    assign rd_word = 32'(cur_line >> rd_sh);
    assign rd_data = lowx_req_uncached_i ? BLK_SIZE'(rd_word) : cur_line;

`ifdef LOWX_MEM_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = CW'(lfsr_q[2:0]);
`else
    assign stall = '0;
`endif

    // Array has no reset: contents survive reset, and a committed write stays.
    always_ff @(posedge clk_i) begin
        if (accept && lowx_req_rw_i) begin
            mem_q[idx] <= new_line;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_WAIT;
                    cnt_d      = CW'(LATENCY - 1) + stall;
                    res_data_d = lowx_req_rw_i ? '0 : rd_data;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (lowx_res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
        end
    end

endmodule

// File: tb/tb_lowx_mem_responder.sv
// tb/tb_lowx_mem_responder.sv - directed scoreboard testbench for lowx_mem_responder
module tb_lowx_mem_responder;

    localparam int LAT = 2;

    logic         clk;
    logic         rst_i;
    logic         lowx_req_valid_i;
    logic         lowx_req_ready_o;
    logic [31:0]  lowx_req_addr_i;
    logic         lowx_req_rw_i;
    logic [1:0]   lowx_req_rw_size_i;
    logic [127:0] lowx_req_data_i;
    logic         lowx_req_uncached_i;
    logic         lowx_res_valid_o;
    logic         lowx_res_ready_i;
    logic [127:0] lowx_res_data_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [127:0] sb_q[$];

    lowx_mem_responder #(
        .BLK_SIZE (128),
        .XLEN     (32),
        .MEM_DEPTH(1024),
        .LATENCY  (LAT)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .lowx_req_valid_i   (lowx_req_valid_i),
        .lowx_req_ready_o   (lowx_req_ready_o),
        .lowx_req_addr_i    (lowx_req_addr_i),
        .lowx_req_rw_i      (lowx_req_rw_i),
        .lowx_req_rw_size_i (lowx_req_rw_size_i),
        .lowx_req_data_i    (lowx_req_data_i),
        .lowx_req_uncached_i(lowx_req_uncached_i),
        .lowx_res_valid_o   (lowx_res_valid_o),
        .lowx_res_ready_i   (lowx_res_ready_i),
        .lowx_res_data_o    (lowx_res_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LOWX_MEM_STALL_EN
    logic [7:0] ref_lfsr;
    always_ff @(posedge clk) begin
        if (rst_i) ref_lfsr <= 8'hA5;
        else       ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end
`endif

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; expected response data goes to the scoreboard at drive time.
    task automatic issue(input logic [31:0] addr, input logic rw, input logic [1:0] sz,
                         input logic [127:0] data, input logic unc,
                         input logic [127:0] exp_data, input int hold);
        int           exp_lat;
        int           lat;
        bit           seen;
        logic [127:0] exp_pop;
        lowx_req_addr_i     = addr;
        lowx_req_rw_i       = rw;
        lowx_req_rw_size_i  = sz;
        lowx_req_data_i     = data;
        lowx_req_uncached_i = unc;
        lowx_req_valid_i    = 1'b1;
        lowx_res_ready_i    = (hold == 0);
        sb_q.push_back(exp_data);
        exp_lat = LAT;
`ifdef LOWX_MEM_STALL_EN
        exp_lat = LAT + int'(ref_lfsr[2:0]);
`endif
        check("req_ready_idle", 128'(lowx_req_ready_o), 128'(1));
        @(posedge clk); #1;
        // Inputs change after acceptance and must be ignored.
        lowx_req_valid_i = 1'b0;
        lowx_req_addr_i  = $urandom;
        lowx_req_data_i  = {$urandom, $urandom, $urandom, $urandom};
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lowx_res_valid_o) seen = 1;
            else check("req_ready_busy", 128'(lowx_req_ready_o), 128'(0));
        end
        check("res_seen", 128'(seen), 128'(1));
        if (seen) begin
            check("latency", 128'(lat), 128'(exp_lat));
`ifdef LOWX_MEM_STALL_EN
            check("latency_range", 128'(lat >= 2 && lat <= 9), 128'(1));
`endif
            exp_pop = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            check("res_data", lowx_res_data_o, exp_pop);
            check("req_ready_resp", 128'(lowx_req_ready_o), 128'(0));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("bp_valid", 128'(lowx_res_valid_o), 128'(1));
                check("bp_data", lowx_res_data_o, exp_pop);
                check("bp_req_ready", 128'(lowx_req_ready_o), 128'(0));
            end
            lowx_res_ready_i = 1'b1;
            @(posedge clk); #1;
            check("post_hs_valid", 128'(lowx_res_valid_o), 128'(0));
            check("post_hs_ready", 128'(lowx_req_ready_o), 128'(1));
        end
    endtask

    localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBABE;
    localparam logic [127:0] D2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] D3 = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] L4 = 128'h11223344_12344567_89ABA5EF_55667788;

    initial begin
        rst_i               = 1'b1;
        lowx_req_valid_i    = 1'b0;
        lowx_req_addr_i     = '0;
        lowx_req_rw_i       = 1'b0;
        lowx_req_rw_size_i  = 2'd0;
        lowx_req_data_i     = '0;
        lowx_req_uncached_i = 1'b0;
        lowx_res_ready_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 128'(lowx_req_ready_o), 128'(0));
        check("rst_res_valid", 128'(lowx_res_valid_o), 128'(0));
        check("rst_res_data", lowx_res_data_o, 128'(0));
        rst_i = 1'b0;
        #1;
        check("rst_release_ready", 128'(lowx_req_ready_o), 128'(1));

        // Cached write then read back.
        issue(32'h40, 1'b1, 2'd0, D1, 1'b0, 128'(0), 0);
        issue(32'h40, 1'b0, 2'd0, '0, 1'b0, D1, 0);

        // Uncached byte write, then aligned-word read.
        issue(32'h45, 1'b1, 2'd0, 128'hA5, 1'b1, 128'(0), 0);
        issue(32'h44, 1'b0, 2'd0, '0, 1'b1, 128'h89ABA5EF, 0);

        // Half (addr[0] ignored), word, and reserved size treated as word.
        issue(32'h4B, 1'b1, 2'd1, 128'hBEEF1234, 1'b1, 128'(0), 0);
        issue(32'h4E, 1'b1, 2'd2, 128'h11223344, 1'b1, 128'(0), 0);
        issue(32'h42, 1'b1, 2'd3, 128'h55667788, 1'b1, 128'(0), 0);
        issue(32'h47, 1'b0, 2'd0, '0, 1'b1, 128'h89ABA5EF, 0);
        issue(32'h40, 1'b0, 2'd0, '0, 1'b0, L4, 0);

        // Response backpressure for 5 cycles.
        issue(32'h40, 1'b0, 2'd0, '0, 1'b0, L4, 5);

        // Line index wraps at MEM_DEPTH.
        issue(32'h4000, 1'b1, 2'd0, D2, 1'b0, 128'(0), 0);
        issue(32'h0, 1'b0, 2'd0, '0, 1'b0, D2, 0);

        // Reset during WAIT of a write: no response, but the write is committed.
        lowx_req_addr_i     = 32'h80;
        lowx_req_rw_i       = 1'b1;
        lowx_req_data_i     = D3;
        lowx_req_uncached_i = 1'b0;
        lowx_req_valid_i    = 1'b1;
        lowx_res_ready_i    = 1'b1;
        @(posedge clk); #1;
        lowx_req_valid_i = 1'b0;
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_valid", 128'(lowx_res_valid_o), 128'(0));
            check("abort_ready", 128'(lowx_req_ready_o), 128'(0));
            check("abort_data", lowx_res_data_o, 128'(0));
        end
        rst_i = 1'b0;
        #1;
        check("abort_release_ready", 128'(lowx_req_ready_o), 128'(1));
        issue(32'h80, 1'b0, 2'd0, '0, 1'b0, D3, 0);

`ifdef LOWX_MEM_STALL_EN
        for (int i = 0; i < 16; i++) begin
            issue(32'h80, 1'b0, 2'd0, '0, 1'b0, D3, 0);
        end
`endif

        check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
